// File: rtl/uart_parity_engine.sv
// rtl/uart_parity_engine.sv - bit-serial UART parity generator/checker (optional stats: PARITY_STATS_EN)
module uart_parity_engine #(
    parameter int  DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic             ParityEn,
    input  logic             CheckMode,
    input  logic             BitValid,
    input  logic             BitIn,
    output logic             Busy,
    output logic             ParityBit,
    output logic             ParityValid,
    output logic             ParityErr,
    output logic             Done,
    output logic [CNT_W-1:0] BitCount,
    output logic [15:0]      ErrCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_EVEN  = 2'b00;
    localparam logic [1:0] MODE_ODD   = 2'b01;
    localparam logic [1:0] MODE_MARK  = 2'b10;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             parity_err_q, parity_err_d;
    logic [1:0]       mode_q, mode_d;
    logic             parity_en_q, parity_en_d;
    logic             check_mode_q, check_mode_d;
    logic             expected;
    logic             par_valid;

    // Expected parity from the running XOR and the mode latched at Start
    always_comb begin
        expected = 1'b0;
        case (mode_q)
            MODE_EVEN: expected = acc_q;
            MODE_ODD:  expected = ~acc_q;
            MODE_MARK: expected = 1'b1;
            default:   expected = 1'b0;
        endcase
    end

    // Next-state logic; Start restarts the frame from any state and swallows a same-cycle bit
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bit_count_d  = bit_count_q;
        parity_err_d = parity_err_q;
        mode_d       = mode_q;
        parity_en_d  = parity_en_q;
        check_mode_d = check_mode_q;
        par_valid    = 1'b0;
        if (Start) begin
            state_d      = ST_DATA;
            acc_d        = 1'b0;
            bit_count_d  = '0;
            parity_err_d = 1'b0;
            mode_d       = Mode;
            parity_en_d  = ParityEn;
            check_mode_d = CheckMode;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DATA: begin
                    if (BitValid) begin
                        acc_d       = acc_q ^ BitIn;
                        bit_count_d = bit_count_q + CNT_W'(1);
                        if (bit_count_q == CNT_W'(DATA_W - 1)) begin
                            state_d = parity_en_q ? ST_PAR : ST_DONE;
                        end
                    end
                end
                ST_PAR: begin
                    if (!check_mode_q) begin
                        par_valid = 1'b1;
                        state_d   = ST_DONE;
                    end else if (BitValid) begin
                        par_valid    = 1'b1;
                        parity_err_d = (BitIn != expected);
                        state_d      = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Frame state and latched configuration
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= 1'b0;
            bit_count_q  <= '0;
            parity_err_q <= 1'b0;
            mode_q       <= 2'b00;
            parity_en_q  <= 1'b0;
            check_mode_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_count_q  <= bit_count_d;
            parity_err_q <= parity_err_d;
            mode_q       <= mode_d;
            parity_en_q  <= parity_en_d;
            check_mode_q <= check_mode_d;
        end
    end

    // Outputs decode from state so that reset clears them asynchronously
    always_comb begin
        Busy        = (state_q != ST_IDLE);
        ParityValid = par_valid;
        ParityBit   = par_valid & expected;
        Done        = (state_q == ST_DONE) && !Start;
        ParityErr   = parity_err_q;
        BitCount    = bit_count_q;
    end

`ifdef PARITY_STATS_EN
    logic [15:0] err_count_q, err_count_d;

    // Count rising edges of the sticky error flag, saturating
    always_comb begin
        err_count_d = err_count_q;
        if (parity_err_d && !parity_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign ErrCount = err_count_q;
`else
    assign ErrCount = 16'd0;
`endif

endmodule
